// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-stage program-counter generator.
package pc_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pc_state_e;

  localparam int          DEF_WIDTH      = 32;
  localparam int          DEF_INST_BYTES = 4;
  localparam logic [63:0] DEF_RESET_PC   = 64'h0;
  localparam int          DEF_RAS_DEPTH  = 4;

  // Number of low PC bits that are always zero for a given fetch granule.
  function automatic int align_bits(input int inst_bytes);
    return $clog2(inst_bytes);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, pushes past full overwrite the oldest entry.
module pc_ras
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // ptr_q addresses the next free slot; the top of stack sits one below it.
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, full_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer/count update; push wins if both are ever asserted together.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_ONE;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_ONE;
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - PTR_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // Control state and flags; flags track the post-edge count.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CNT_FULL);
    end
  end

  // Entry storage; contents are meaningless once the count is cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i && push_i) mem_q[ptr_q] <= push_data_i;
  end

  assign top_o   = mem_q[ptr_q - PTR_ONE];
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: IDLE/RUN control, redirect/stall/call/return next-PC mux.
//
//   state | meaning
//   IDLE  | fetch paused, pc held (redirect still loads it), pc_valid_o = 0
//   RUN   | fetching, pc_o valid, next PC chosen by priority mux
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter int               INST_BYTES = DEF_INST_BYTES,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
  parameter int               RAS_DEPTH  = DEF_RAS_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic             call_i,
  input  logic [WIDTH-1:0] call_target_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid_o,
  output logic             ras_empty_o,
  output logic             ras_full_o
);

  localparam int ALIGN_BITS = align_bits(INST_BYTES);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push, ras_pop;
  logic             ras_empty, ras_full;

  function automatic logic [WIDTH-1:0] align_pc(input logic [WIDTH-1:0] a);
    return (a >> ALIGN_BITS) << ALIGN_BITS;
  endfunction

  // Wraps silently at 2^WIDTH.
  assign pc_seq = pc_q + WIDTH'(INST_BYTES);

  // State and PC registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, next PC and RAS requests.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
        if (redirect_i) pc_d = align_pc(redirect_pc_i);
      end
      RUN: begin
        if (!start_i) begin
          // Leaving RUN: only a redirect may move the PC so it is not lost.
          state_d = IDLE;
          if (redirect_i) pc_d = align_pc(redirect_pc_i);
        end else if (redirect_i) begin
          pc_d = align_pc(redirect_pc_i);
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (call_i) begin
          ras_push = 1'b1;
          pc_d     = align_pc(call_target_i);
        end else if (ret_i && !ras_empty) begin
          ras_pop = 1'b1;
          pc_d    = ras_top;
        end else begin
          // Includes a return with an empty stack; EX will redirect if wrong.
          pc_d = pc_seq;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    pc_o        = pc_q;
    pc_valid_o  = (state_q == RUN);
    ras_empty_o = ras_empty;
    ras_full_o  = ras_full;
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_seq),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Table-driven bench for pc_gen with an expected-value scoreboard queue.
module tb_pc_gen;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, stall_i, redirect_i, call_i, ret_i;
  logic [31:0] redirect_pc_i, call_target_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, ras_empty_o, ras_full_o;

  pc_gen #(
    .WIDTH      (32),
    .INST_BYTES (4),
    .RESET_PC   (32'h0),
    .RAS_DEPTH  (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .call_i        (call_i),
    .call_target_i (call_target_i),
    .ret_i         (ret_i),
    .pc_o          (pc_o),
    .pc_valid_o    (pc_valid_o),
    .ras_empty_o   (ras_empty_o),
    .ras_full_o    (ras_full_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit [63:0]   tag;
    logic        rst, start, stall, redir;
    logic [31:0] rpc;
    logic        call;
    logic [31:0] ctgt;
    logic        ret;
    logic [31:0] epc;
    logic        ev, ee, ef;
  } vec_t;

  typedef struct {
    bit [63:0]   tag;
    logic [31:0] pc;
    logic        v, e, f;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input bit [63:0] tag, input logic rst, input logic st,
                     input logic stl, input logic rd, input logic [31:0] rpc,
                     input logic cl, input logic [31:0] ct, input logic rt,
                     input logic [31:0] epc, input logic ev, input logic ee,
                     input logic ef);
    vec_t v;
    v.tag = tag; v.rst = rst; v.start = st; v.stall = stl; v.redir = rd;
    v.rpc = rpc; v.call = cl; v.ctgt = ct; v.ret = rt;
    v.epc = epc; v.ev = ev; v.ee = ee; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    exp_t e, got;
    @(negedge clk_i);
    rst_i = v.rst; start_i = v.start; stall_i = v.stall; redirect_i = v.redir;
    redirect_pc_i = v.rpc; call_i = v.call; call_target_i = v.ctgt; ret_i = v.ret;
    e.tag = v.tag; e.pc = v.epc; e.v = v.ev; e.e = v.ee; e.f = v.ef;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    got = sb_q.pop_front();
    n_vec++;
    if (pc_o !== got.pc || pc_valid_o !== got.v || ras_empty_o !== got.e ||
        ras_full_o !== got.f) begin
      n_bad++;
      $display("FAIL %0s (vec %0d): got pc=%h valid=%b empty=%b full=%b, want pc=%h valid=%b empty=%b full=%b",
               got.tag, n_vec, pc_o, pc_valid_o, ras_empty_o, ras_full_o,
               got.pc, got.v, got.e, got.f);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; call_i = 1'b0; call_target_i = '0; ret_i = 1'b0;

    //   tag        rst st stl rd rpc           cl ct            rt  pc            v  e  f
    add("reset",    0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 1, 0);
    add("reset2",   0, 1, 0, 1, 32'h500,      0, 32'h0,        0, 32'h0,        0, 1, 0);
    // start, sequential fetch, pause
    add("start",    1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 1, 0);
    add("seq4",     1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        1, 1, 0);
    add("seq8",     1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        1, 1, 0);
    add("seqC",     1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 1, 0);
    add("stop",     1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'hC,        0, 1, 0);
    add("idle",     1, 0, 0, 0, 32'h0,        1, 32'h900,      1, 32'hC,        0, 1, 0);
    add("restart",  1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'hC,        1, 1, 0);
    add("seq10",    1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h10,       1, 1, 0);
    // stall then redirect under stall, misaligned target
    add("stall1",   1, 1, 1, 0, 32'h0,        1, 32'h700,      0, 32'h10,       1, 1, 0);
    add("stall2",   1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h10,       1, 1, 0);
    add("redir",    1, 1, 1, 1, 32'h103,      1, 32'h700,      0, 32'h100,      1, 1, 0);
    // single call / return
    add("to20",     1, 1, 0, 1, 32'h20,       0, 32'h0,        0, 32'h20,       1, 1, 0);
    add("call",     1, 1, 0, 0, 32'h0,        1, 32'h200,      0, 32'h200,      1, 0, 0);
    add("s204",     1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h204,      1, 0, 0);
    add("s208",     1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h208,      1, 0, 0);
    add("ret",      1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h24,       1, 1, 0);
    // five nested calls, overflow, five returns
    add("to0",      1, 1, 0, 1, 32'h0,        0, 32'h0,        0, 32'h0,        1, 1, 0);
    add("c1",       1, 1, 0, 0, 32'h0,        1, 32'h100,      0, 32'h100,      1, 0, 0);
    add("c2",       1, 1, 0, 0, 32'h0,        1, 32'h200,      0, 32'h200,      1, 0, 0);
    add("c3",       1, 1, 0, 0, 32'h0,        1, 32'h300,      0, 32'h300,      1, 0, 0);
    add("c4",       1, 1, 0, 0, 32'h0,        1, 32'h400,      0, 32'h400,      1, 0, 1);
    add("c5",       1, 1, 0, 0, 32'h0,        1, 32'h500,      0, 32'h500,      1, 0, 1);
    add("r1",       1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h404,      1, 0, 0);
    add("r2",       1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h304,      1, 0, 0);
    add("r3",       1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h204,      1, 0, 0);
    add("r4",       1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h104,      1, 1, 0);
    add("r5empty",  1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h108,      1, 1, 0);
    // wrap and call+ret together
    add("toFFFC",   1, 1, 0, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 32'hFFFFFFFC, 1, 1, 0);
    add("wrap",     1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 1, 0);
    add("to40",     1, 1, 0, 1, 32'h40,       0, 32'h0,        0, 32'h40,       1, 1, 0);
    add("callret",  1, 1, 0, 0, 32'h0,        1, 32'h80,       1, 32'h80,       1, 0, 0);
    add("ret44",    1, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h44,       1, 1, 0);
    // misaligned call target, then reset with two entries live
    add("callmis",  1, 1, 0, 0, 32'h0,        1, 32'h303,      0, 32'h300,      1, 0, 0);
    add("call2",    1, 1, 0, 0, 32'h0,        1, 32'h400,      0, 32'h400,      1, 0, 0);
    add("rstrun",   0, 1, 0, 1, 32'h600,      1, 32'h700,      0, 32'h0,        0, 1, 0);
    add("postrst",  1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 1, 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Hand-written: redirect while IDLE, redirect honoured in RUN->IDLE exit,
    // call/ret ignored on exit and entry, stall blocks a call.
    vecs.delete();
    add("idleredir", 1, 0, 0, 1, 32'h55,      0, 32'h0,        0, 32'h54,       0, 1, 0);
    add("go",        1, 1, 0, 0, 32'h0,       0, 32'h0,        0, 32'h54,       1, 1, 0);
    add("exitredir", 1, 0, 0, 1, 32'h600,     1, 32'h900,      0, 32'h600,      0, 1, 0);
    add("exitidle",  1, 0, 0, 0, 32'h0,       0, 32'h0,        0, 32'h600,      0, 1, 0);
    add("enterret",  1, 1, 0, 0, 32'h0,       1, 32'h900,      1, 32'h600,      1, 1, 0);
    add("stallcall", 1, 1, 1, 0, 32'h0,       1, 32'h900,      0, 32'h600,      1, 1, 0);
    add("call9",     1, 1, 0, 0, 32'h0,       1, 32'h900,      0, 32'h900,      1, 0, 0);
    add("exitcall",  1, 0, 0, 0, 32'h0,       1, 32'hA00,      0, 32'h900,      0, 0, 0);
    add("reenter",   1, 1, 0, 0, 32'h0,       0, 32'h0,        0, 32'h900,      1, 0, 0);
    add("stallret",  1, 1, 1, 0, 32'h0,       0, 32'h0,        1, 32'h900,      1, 0, 0);
    add("ret604",    1, 1, 0, 0, 32'h0,       0, 32'h0,        1, 32'h604,      1, 1, 0);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage; it is the next generation of the single-register PC.
- Adds a start/idle state machine and a hazard stall.
- Adds a prioritised redirect (branch/jump resolved in EX) and sequential increment.
- Adds a small return-address stack (RAS) that predicts returns from same-cycle predecode.
- Feeds instruction-memory address and fetch-valid to the IF/ID pipeline register.

Parameters:
- WIDTH, 32, PC/address width in bits.
- INST_BYTES, 4, increment per sequential fetch; power of two, at least 1.
- RESET_PC, 0, PC value after reset.
- RAS_DEPTH, 4, return-address-stack entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- start_i  in  1  run enable: 1 = fetch, 0 = pause.
- stall_i  in  1  hazard-unit stall: hold PC, no RAS activity.
- redirect_i  in  1  EX-stage branch-taken/jump/mispredict; overrides everything.
- redirect_pc_i  in  WIDTH  redirect target.
- call_i  in  1  predecode: instruction at pc_o is a call.
- call_target_i  in  WIDTH  call target from predecode.
- ret_i  in  1  predecode: instruction at pc_o is a return.
- pc_o  out  WIDTH  current fetch address.
- pc_valid_o  out  1  pc_o is a valid fetch this cycle.
- ras_empty_o  out  1  RAS holds no entries.
- ras_full_o  out  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset (rst_i=0 at a clock edge, which takes precedence over all other inputs):
  - state = IDLE; pc_o = RESET_PC; pc_valid_o = 0.
  - RAS count = 0 and pointer = 0, so ras_empty_o = 1 and ras_full_o = 0.
  - Reset during RUN discards all in-flight RAS contents.
- States:
  - IDLE: pc_o holds; pc_valid_o = 0. start_i = 1 moves to RUN next cycle with pc_o unchanged, so the first valid fetch is the held PC. Other inputs are ignored, except redirect_i, which still loads pc_o.
  - RUN: pc_valid_o = 1. start_i = 0 moves to IDLE next cycle; in that transition cycle only redirect_i is honoured, so no redirect is lost.
- Next-PC priority in RUN (one edge, zero extra latency):
  1. redirect_i: pc_o = redirect_pc_i with the low log2(INST_BYTES) bits forced to 0. call_i/ret_i are suppressed, no RAS change.
  2. stall_i: pc_o holds; no push/pop.
  3. call_i: push pc_o+INST_BYTES; pc_o = call_target_i (aligned as above). If call_i and ret_i are both 1, call wins and ret is ignored.
  4. ret_i with RAS non-empty: pop; pc_o = popped entry.
  5. ret_i with RAS empty: treat as sequential; EX redirect later corrects.
  6. Otherwise: pc_o = pc_o + INST_BYTES.
- Arithmetic is modulo 2^WIDTH: all-ones-aligned + INST_BYTES wraps to 0 without any flag.
- RAS:
  - Circular buffer; push when full overwrites the oldest entry and count saturates at RAS_DEPTH.
  - Pop decrements count and steps the pointer back.
  - The value pushed is always the address sequential to the call.
  - Flags are registered and reflect the post-edge count.

Decomposition:
- Shared package pc_gen_pkg:
  - state enum {IDLE, RUN};
  - default parameter constants;
  - ALIGN_BITS = log2(INST_BYTES) helper.
- Sub-module pc_ras: push/pop/data, circular storage, count, empty/full, synchronous active-low reset. pc_gen owns the FSM and next-PC mux.

Test Plan:
All scenarios use WIDTH=32, INST_BYTES=4, RESET_PC=0x0, RAS_DEPTH=4.
1. Reset then start_i=1 for 4 cycles → pc_o 0x0 (valid=0), then 0x0, 0x4, 0x8 with valid=1; start_i=0 → pc_o holds, valid=0 the next cycle.
2. At pc 0x10, stall_i=1 for 2 cycles then redirect_i=1 with stall_i=1 and redirect_pc_i=0x103 → pc 0x10, 0x10, then 0x100; RAS unchanged.
3. At pc 0x20, call_i with target 0x200; run to 0x208; ret_i=1 → pc 0x200…0x208, then 0x24; ras_empty_o=1 again.
4. Five nested calls from 0x0, 0x100, 0x200, 0x300, 0x400 → ras_full_o=1; five returns yield 0x404, 0x304, 0x204, 0x104, then sequential at the last return (stack empty; oldest overwritten).
5. pc_o=0xFFFFFFFC sequential → 0x00000000; call_i and ret_i together at 0x40 with target 0x80 → pc 0x80, push 0x44.
6. rst_i=0 during RUN with 2 RAS entries → next cycle pc_o=0x0, valid=0, IDLE, ras_empty_o=1.
